// File: rtl/accuml_ctrl_pkg.sv
// Shared math package for the frame accumulator.
// Holds the controller state encoding and the add/sub op constants.
package accuml_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    ACC,
    OUT
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/accuml_ctrl_accuml.sv
// accuml: WIDTH+1 bit add/sub accumulator, wraps modulo 2^(WIDTH+1).
// Ports: clock, reset (async high), clr, add_sub, d (unsigned), q.
module accuml
  import accuml_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             add_sub,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   q
);

  logic [WIDTH:0] q_q;
  logic [WIDTH:0] q_d;
  logic [WIDTH:0] d_ext;

  assign d_ext = {1'b0, d};

  always_comb begin
    q_d = q_q + d_ext;
    if (clr) begin
      q_d = '0;
    end else if (add_sub == OP_SUB) begin
      q_d = q_q - d_ext;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/accuml_ctrl.sv
// accuml_ctrl: frame controller summing len signed-op samples.
// Ports: clock/reset, start+len, s_* sample stream, m_* result, busy.
module accuml_ctrl
  import accuml_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_sub,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH:0]   m_data,
  input  logic             m_ready,
  output logic             busy
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;

  logic             acc_clr;
  logic             acc_op;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH:0]   acc_q;

  accuml #(
    .WIDTH(WIDTH)
  ) u_accuml (
    .clock  (clock),
    .reset  (reset),
    .clr    (acc_clr),
    .add_sub(acc_op),
    .d      (acc_d),
    .q      (acc_q)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_clr = 1'b0;
    acc_op  = OP_ADD;
    acc_d   = '0;
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = CLR;
          rem_d   = len;
        end
      end
      CLR: begin
        acc_clr = 1'b1;
        state_d = (rem_q != '0) ? ACC : OUT;
      end
      ACC: begin
        s_ready = 1'b1;
        if (s_valid) begin
          acc_d  = s_data;
          acc_op = s_sub;
          rem_d  = rem_q - 1'b1;
          // last sample lands in Q on this edge
          if (rem_q == CNT_W'(1)) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // result is only exposed while it is being offered
  assign m_data = m_valid ? acc_q : '0;

endmodule

// File: tb/tb_accuml_ctrl.sv
// Self-checking bench for accuml_ctrl.
// Directed frames plus random traffic against a frame-level model.
module tb_accuml_ctrl;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic          start   = 1'b0;
  logic [CW-1:0] len     = '0;
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_data  = '0;
  logic          s_sub   = 1'b0;
  logic          m_ready = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic [W:0]    m_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  accuml_ctrl #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .len    (len),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_sub  (s_sub),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_ready(m_ready),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  // Frame-level model: a frame is open, its sum has been zeroed,
  // some samples are still owed, and the running sum.
  logic       f_open    = 1'b0;
  logic       f_zeroed  = 1'b0;
  int         f_left    = 0;
  logic [W:0] f_sum     = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      f_open   <= 1'b0;
      f_zeroed <= 1'b0;
      f_left   <= 0;
      f_sum    <= '0;
    end else if (!f_open) begin
      if (start) begin
        f_open   <= 1'b1;
        f_zeroed <= 1'b0;
        f_left   <= int'(len);
      end
    end else if (!f_zeroed) begin
      f_zeroed <= 1'b1;
      f_sum    <= '0;
    end else if (f_left > 0) begin
      if (s_valid) begin
        f_sum  <= s_sub ? f_sum - {1'b0, s_data}
                        : f_sum + {1'b0, s_data};
        f_left <= f_left - 1;
      end
    end else if (m_ready) begin
      f_open <= 1'b0;
    end
  end

  logic       e_busy;
  logic       e_sready;
  logic       e_mvalid;
  logic [W:0] e_mdata;

  assign e_busy   = f_open;
  assign e_sready = f_open && f_zeroed && (f_left > 0);
  assign e_mvalid = f_open && f_zeroed && (f_left == 0);
  assign e_mdata  = e_mvalid ? f_sum : '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clock) begin
    chk("busy", 32'(busy), 32'(e_busy));
    chk("s_ready", 32'(s_ready), 32'(e_sready));
    chk("m_valid", 32'(m_valid), 32'(e_mvalid));
    chk("m_data", 32'(m_data), 32'(e_mdata));
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [W-1:0] d, input logic sub);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_sub   = sub;
    n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!m_valid && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("out_timeout", 32'd1, 32'd0);
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  task automatic begin_frame(input logic [CW-1:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sready"}, 32'(s_ready), 32'd0);
    chk({tag, "_mvalid"}, 32'(m_valid), 32'd0);
    chk({tag, "_mdata"}, 32'(m_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1;
    chk_reset_vals("rst0");
    step();
    step();
    reset = 1'b0;
    step();

    // four adds, s_valid held high
    begin_frame(8'd4);
    step();
    send(16'd100, 1'b0);
    send(16'd200, 1'b0);
    send(16'd300, 1'b0);
    send(16'd400, 1'b0);
    chk("f1_lat", 32'(m_valid), 32'd1);
    chk("f1_data", 32'(m_data), 32'd1000);
    chk("f1_model", 32'(f_sum), 32'd1000);
    handshake();
    chk("f1_idle", 32'(busy), 32'd0);

    // gapped samples, mixed ops, stray start in ACC
    begin_frame(8'd3);
    step();
    send(16'd500, 1'b0);
    start = 1'b1;
    chk("f2_gap_rdy", 32'(s_ready), 32'd1);
    step();
    start = 1'b0;
    send(16'd200, 1'b1);
    chk("f2_gap_rdy2", 32'(s_ready), 32'd1);
    step();
    send(16'd50, 1'b1);
    chk("f2_lat", 32'(m_valid), 32'd1);
    chk("f2_data", 32'(m_data), 32'd250);
    handshake();

    // wrap below zero, result held under backpressure
    begin_frame(8'd2);
    step();
    send(16'd0, 1'b0);
    send(16'd1, 1'b1);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      chk("f3_hold", 32'(m_data), 32'h1FFFF);
      step();
    end
    chk("f3_model", 32'(f_sum), 32'h1FFFF);
    handshake();
    chk("f3_idle", 32'(busy), 32'd0);

    // empty frame, start held through CLR/OUT and at handshake
    start = 1'b1;
    len   = 8'd0;
    step();
    step();
    chk("f4_mvalid", 32'(m_valid), 32'd1);
    chk("f4_data", 32'(m_data), 32'd0);
    step();
    m_ready = 1'b1;
    step();
    start   = 1'b0;
    m_ready = 1'b0;
    chk("f4_idle", 32'(busy), 32'd0);
    step();
    chk("f4_still_idle", 32'(busy), 32'd0);

    // reset mid-frame, then a fresh one-sample frame
    begin_frame(8'd4);
    step();
    send(16'd11, 1'b0);
    send(16'd22, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk_reset_vals("rst1");
    step();
    reset = 1'b0;
    step();
    chk("rst1_nostart", 32'(busy), 32'd0);
    begin_frame(8'd1);
    step();
    send(16'd7, 1'b0);
    chk("f5_data", 32'(m_data), 32'd7);
    handshake();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 4) == 0);
      len     = CW'($urandom_range(0, 5));
      s_valid = ($urandom_range(0, 9) < 6);
      s_data  = W'($urandom);
      s_sub   = $urandom_range(0, 1) == 1;
      m_ready = $urandom_range(0, 1) == 1;
      reset   = ($urandom_range(0, 299) == 0);
      step();
    end
    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks,
             errors);
    $finish;
  end

endmodule
